// File: rtl/safe_pkg.sv
// Shared definitions for the safe controller: panel channel indices and the
// 2-bit debounce state encoding used by the conditioner, decoder and master FSM.
package safe_pkg;

  localparam int CH_A       = 0;
  localparam int CH_B       = 1;
  localparam int CH_LOCK    = 2;
  localparam int CH_OPEN    = 3;
  localparam int CH_DOORCLS = 4;
  localparam int N_CH       = 5;

  localparam logic [1:0] ST_LO  = 2'd0;
  localparam logic [1:0] ST_WHI = 2'd1;
  localparam logic [1:0] ST_HI  = 2'd2;
  localparam logic [1:0] ST_WLO = 2'd3;

  function automatic logic [N_CH-1:0] ch_bit(input int ch);
    return N_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/safe_input_conditioner_if.sv
// Panel-input bundle between the raw switch side (master) and the conditioner (slave).
// No handshake: raw is sampled every clock, level/rise/fall are registered every clock.
interface safe_input_conditioner_if #(
  parameter int N_IN = 5
);
  logic [N_IN-1:0]   raw;
  logic [N_IN-1:0]   level;
  logic [N_IN-1:0]   rise;
  logic [N_IN-1:0]   fall;
  logic [2*N_IN-1:0] dbg_state;

  modport master (output raw, input level, rise, fall, dbg_state);
  modport slave  (input raw, output level, rise, fall, dbg_state);
endinterface

// File: rtl/safe_deb_channel.sv
// One conditioned bit: synchroniser, 4-state debounce FSM with counter and,
// when SAFE_INPUT_AUTOREPEAT_EN is defined, a hold/repeat pulse generator.
module safe_deb_channel
  import safe_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 20,
  parameter int HOLD_DLY    = 500,
  parameter int REPEAT_PER  = 150,
  parameter bit REPEAT_EN   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_i,
  output logic       level_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic [1:0] state_o
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   rep_pulse;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LO: begin
        // With DEB_CYCLES=1 the first high sample is already enough to accept.
        if (s) begin
          if (CNT_LAST == '0) begin
            state_d = ST_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = ST_WHI;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_WHI: begin
        if (!s) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HI: begin
        if (!s) begin
          if (CNT_LAST == '0) begin
            state_d = ST_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = ST_WLO;
            cnt_d   = CW'(1);
          end
        end else begin
          rise_d = rep_pulse;
        end
      end
      ST_WLO: begin
        if (s) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= ST_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

`ifdef SAFE_INPUT_AUTOREPEAT_EN
  if (REPEAT_EN) begin : g_rep
    localparam int HW = $clog2(HOLD_DLY + 1);
    localparam int PW = $clog2(REPEAT_PER + 1);
    logic [HW-1:0] hold_q;
    logic [PW-1:0] per_q;
    logic          in_hold;

    // Counting only while the press is still being held in ST_HI.
    assign in_hold = (state_q == ST_HI) && s;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        hold_q <= '0;
        per_q  <= '0;
      end else if (!in_hold) begin
        hold_q <= '0;
        per_q  <= '0;
      end else if (hold_q != HW'(HOLD_DLY)) begin
        hold_q <= hold_q + HW'(1);
      end else if (per_q == PW'(REPEAT_PER - 1)) begin
        per_q <= '0;
      end else begin
        per_q <= per_q + PW'(1);
      end
    end

    assign rep_pulse = in_hold &&
                       ((hold_q == HW'(HOLD_DLY - 1)) ||
                        ((hold_q == HW'(HOLD_DLY)) && (per_q == PW'(REPEAT_PER - 1))));
  end else begin : g_norep
    assign rep_pulse = 1'b0;
  end
`else
  assign rep_pulse = 1'b0;
`endif

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign state_o = state_q;

endmodule

// File: rtl/safe_input_conditioner.sv
// Synchronises and debounces all panel inputs; one safe_deb_channel per bit.
// Optional auto-repeat on held buttons is built when SAFE_INPUT_AUTOREPEAT_EN is defined.
module safe_input_conditioner
  import safe_pkg::*;
#(
  parameter int              N_IN        = 5,
  parameter int              SYNC_STAGES = 2,
  parameter int              DEB_CYCLES  = 20,
  parameter int              HOLD_DLY    = 500,
  parameter int              REPEAT_PER  = 150,
  parameter logic [N_IN-1:0] REPEAT_MASK = N_IN'(5'b00011)
) (
  input  logic                     clk,
  input  logic                     rst,
  safe_input_conditioner_if.slave  bus
);

  logic [N_IN-1:0]   level_w;
  logic [N_IN-1:0]   rise_w;
  logic [N_IN-1:0]   fall_w;
  logic [2*N_IN-1:0] state_w;

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    safe_deb_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES),
      .HOLD_DLY    (HOLD_DLY),
      .REPEAT_PER  (REPEAT_PER),
      .REPEAT_EN   (REPEAT_MASK[i])
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (bus.raw[i]),
      .level_o (level_w[i]),
      .rise_o  (rise_w[i]),
      .fall_o  (fall_w[i]),
      .state_o (state_w[2*i +: 2])
    );
  end

  assign bus.level     = level_w;
  assign bus.rise      = rise_w;
  assign bus.fall      = fall_w;
  assign bus.dbg_state = state_w;

endmodule

// File: tb/tb_safe_input_conditioner.sv
// Directed bench for safe_input_conditioner with DEB_CYCLES=4, SYNC_STAGES=2,
// HOLD_DLY=10, REPEAT_PER=3; inputs driven and outputs sampled on the falling edge.
module tb_safe_input_conditioner;
  import safe_pkg::*;

  localparam int N = 5;

`ifdef SAFE_INPUT_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  safe_input_conditioner_if #(.N_IN(N)) bus();

  safe_input_conditioner #(
    .N_IN        (N),
    .SYNC_STAGES (2),
    .DEB_CYCLES  (4),
    .HOLD_DLY    (10),
    .REPEAT_PER  (3),
    .REPEAT_MASK (5'b00011)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [N-1:0] exp_rise, exp_level;
    rst = 1'b0;
    bus.raw = 5'b10000;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.level !== 5'b0) begin n_err++; $display("FAIL reset_level got %b want %b", bus.level, 5'b0); end
    n_vec++; if (bus.rise !== 5'b0) begin n_err++; $display("FAIL reset_rise got %b want %b", bus.rise, 5'b0); end
    n_vec++; if (bus.fall !== 5'b0) begin n_err++; $display("FAIL reset_fall got %b want %b", bus.fall, 5'b0); end
    n_vec++; if (bus.dbg_state !== 10'b0) begin n_err++; $display("FAIL reset_state got %b want %b", bus.dbg_state, 10'b0); end
    rst = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      exp_rise  = (n == 6) ? 5'b10000 : 5'b00000;
      exp_level = (n >= 6) ? 5'b10000 : 5'b00000;
      n_vec++; if (bus.rise !== exp_rise) begin n_err++; $display("FAIL release_rise n=%0d got %b want %b", n, bus.rise, exp_rise); end
      n_vec++; if (bus.level !== exp_level) begin n_err++; $display("FAIL release_level n=%0d got %b want %b", n, bus.level, exp_level); end
      n_vec++; if (bus.fall !== 5'b0) begin n_err++; $display("FAIL release_fall n=%0d got %b want %b", n, bus.fall, 5'b0); end
    end
  endtask

  task automatic test_clean_press();
    logic [N-1:0] exp_rise, exp_level, exp_fall;
    logic r0;
    bus.raw[CH_A] = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      r0 = (n == 6) || (AR && n >= 16 && n <= 22 && ((n - 16) % 3 == 0));
      exp_rise  = {4'b0000, r0};
      exp_level = {4'b1000, (n >= 6 && n < 26)};
      exp_fall  = {4'b0000, (n == 26)};
      n_vec++; if (bus.rise !== exp_rise) begin n_err++; $display("FAIL press_rise n=%0d got %b want %b", n, bus.rise, exp_rise); end
      n_vec++; if (bus.level !== exp_level) begin n_err++; $display("FAIL press_level n=%0d got %b want %b", n, bus.level, exp_level); end
      n_vec++; if (bus.fall !== exp_fall) begin n_err++; $display("FAIL press_fall n=%0d got %b want %b", n, bus.fall, exp_fall); end
      if (n == 20) bus.raw[CH_A] = 1'b0;
    end
  endtask

  task automatic test_bounce();
    logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [N-1:0] exp_rise, exp_level;
    bus.raw[CH_B] = pat[0];
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      exp_rise  = {3'b000, (n == 11), 1'b0};
      exp_level = {3'b100, (n >= 11), 1'b0};
      n_vec++; if (bus.rise !== exp_rise) begin n_err++; $display("FAIL bounce_rise n=%0d got %b want %b", n, bus.rise, exp_rise); end
      n_vec++; if (bus.level !== exp_level) begin n_err++; $display("FAIL bounce_level n=%0d got %b want %b", n, bus.level, exp_level); end
      n_vec++; if (bus.fall !== 5'b0) begin n_err++; $display("FAIL bounce_fall n=%0d got %b want %b", n, bus.fall, 5'b0); end
      if (n <= 8) bus.raw[CH_B] = pat[n];
    end
    bus.raw[CH_B] = 1'b0;
    repeat (12) @(negedge clk);
    n_vec++; if (bus.level !== 5'b10000) begin n_err++; $display("FAIL bounce_release got %b want %b", bus.level, 5'b10000); end
  endtask

  task automatic test_glitch();
    bus.raw[CH_B] = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      n_vec++; if (bus.level !== 5'b10000) begin n_err++; $display("FAIL glitch_level n=%0d got %b want %b", n, bus.level, 5'b10000); end
      n_vec++; if ((bus.rise | bus.fall) !== 5'b0) begin n_err++; $display("FAIL glitch_pulse n=%0d got %b want %b", n, bus.rise | bus.fall, 5'b0); end
      if (n == 3) bus.raw[CH_B] = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] exp_rise, exp_level;
    bus.raw[CH_LOCK] = 1'b1;
    bus.raw[CH_OPEN] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      exp_rise  = (n == 6) ? 5'b01100 : 5'b00000;
      exp_level = (n >= 6) ? 5'b11100 : 5'b10000;
      n_vec++; if (bus.rise !== exp_rise) begin n_err++; $display("FAIL simul_rise n=%0d got %b want %b", n, bus.rise, exp_rise); end
      n_vec++; if (bus.level !== exp_level) begin n_err++; $display("FAIL simul_level n=%0d got %b want %b", n, bus.level, exp_level); end
      n_vec++; if (bus.fall !== 5'b0) begin n_err++; $display("FAIL simul_fall n=%0d got %b want %b", n, bus.fall, 5'b0); end
    end
  endtask

  task automatic test_autorepeat();
    logic [N-1:0] exp_rise, exp_level;
    logic r0;
    bus.raw[CH_A] = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      r0 = (n == 6) || (AR && n >= 16 && ((n - 16) % 3 == 0));
      exp_rise  = {4'b0000, r0};
      exp_level = {4'b1110, (n >= 6)};
      n_vec++; if (bus.rise !== exp_rise) begin n_err++; $display("FAIL hold_rise n=%0d got %b want %b", n, bus.rise, exp_rise); end
      n_vec++; if (bus.level !== exp_level) begin n_err++; $display("FAIL hold_level n=%0d got %b want %b", n, bus.level, exp_level); end
    end
    bus.raw[CH_A] = 1'b0;
    repeat (10) @(negedge clk);
    n_vec++; if (bus.level !== 5'b11100) begin n_err++; $display("FAIL hold_release got %b want %b", bus.level, 5'b11100); end
  endtask

  task automatic test_reset_abort();
    bus.raw[CH_B] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (bus.level !== 5'b0) begin n_err++; $display("FAIL abort_level got %b want %b", bus.level, 5'b0); end
    n_vec++; if ((bus.rise | bus.fall) !== 5'b0) begin n_err++; $display("FAIL abort_pulse got %b want %b", bus.rise | bus.fall, 5'b0); end
    n_vec++; if (bus.dbg_state !== 10'b0) begin n_err++; $display("FAIL abort_state got %b want %b", bus.dbg_state, 10'b0); end
    bus.raw = 5'b00000;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      n_vec++; if (bus.level !== 5'b0) begin n_err++; $display("FAIL abort_after_level n=%0d got %b want %b", n, bus.level, 5'b0); end
      n_vec++; if ((bus.rise | bus.fall) !== 5'b0) begin n_err++; $display("FAIL abort_after_pulse n=%0d got %b want %b", n, bus.rise | bus.fall, 5'b0); end
    end
  endtask

  initial begin
    bus.raw = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_autorepeat();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
